// File: rtl/spi_sf_target.sv
// Quad-SPI serial-flash responder that maps flash commands onto a byte-wide memory port.
// Define QUAD_READ_EN to support the 0x6B quad output read (DUMMY and READ4 states).
module spi_sf_target #(
    parameter int SYNC_STAGES     = 2,
    parameter int QUAD_DUMMY_CLKS = 8,
    parameter int MEM_LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c,
    input  logic        s,
    input  logic [3:0]  dq_i,
    output logic [3:0]  dq_o,
    output logic [3:0]  dq_t,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    output logic        wel,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        illegal_cmd
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_READ1,
        ST_READ4, ST_STATUS, ST_WRITE, ST_IGNORE
    } state_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_SET, ACT_CLR} act_t;

    logic [SYNC_STAGES-1:0]      r_c_sync;
    logic [SYNC_STAGES-1:0]      r_s_sync;
    logic [SYNC_STAGES-1:0][3:0] r_dq_sync;
    logic                        r_c_prev;
    state_t                      r_state;
    state_t                      r_after;
    act_t                        r_act;
    logic [4:0]                  r_bit_cnt;
    logic [2:0]                  r_out_cnt;
    logic [7:0]                  r_shift_in;
    logic [7:0]                  r_shift_out;
    logic [1:0]                  r_rd_pipe;
`ifdef QUAD_READ_EN
    logic [7:0]                  r_dummy_cnt;
`else
    logic [31:0]                 w_unused_quad_cfg;
    assign w_unused_quad_cfg = 32'(QUAD_DUMMY_CLKS);
`endif

    logic       w_c, w_s, w_din, w_rise, w_fall, w_rdata_valid;
    logic [3:0] w_dq;
    logic [7:0] w_byte, w_status;
    logic       w_unused_bits;

    assign w_c           = r_c_sync[SYNC_STAGES-1];
    assign w_s           = r_s_sync[SYNC_STAGES-1];
    assign w_dq          = r_dq_sync[SYNC_STAGES-1];
    assign w_din         = w_dq[0];
    assign w_rise        = w_c & ~r_c_prev;
    assign w_fall        = ~w_c & r_c_prev;
    assign w_byte        = {r_shift_in[6:0], w_din};
    assign w_status      = {6'b0, wel, 1'b0};
    assign w_rdata_valid = r_rd_pipe[MEM_LATENCY-1];
    assign w_unused_bits = ^{w_dq[3:1], r_rd_pipe};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_sync    <= '0;
            r_s_sync    <= '1;
            r_dq_sync   <= '0;
            r_c_prev    <= 1'b0;
            r_state     <= ST_IDLE;
            r_after     <= ST_IGNORE;
            r_act       <= ACT_NONE;
            r_bit_cnt   <= 5'd0;
            r_out_cnt   <= 3'd0;
            r_shift_in  <= 8'h00;
            r_shift_out <= 8'h00;
            r_rd_pipe   <= 2'b00;
`ifdef QUAD_READ_EN
            r_dummy_cnt <= 8'd0;
`endif
            dq_o        <= 4'b0000;
            dq_t        <= 4'b1111;
            mem_addr    <= 24'h000000;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_wdata   <= 8'h00;
            wel         <= 1'b0;
            cmd_byte    <= 8'h00;
            cmd_valid   <= 1'b0;
            illegal_cmd <= 1'b0;
        end else begin
            r_c_sync    <= {r_c_sync[SYNC_STAGES-2:0], c};
            r_s_sync    <= {r_s_sync[SYNC_STAGES-2:0], s};
            r_dq_sync   <= {r_dq_sync[SYNC_STAGES-2:0], dq_i};
            r_c_prev    <= w_c;
            r_rd_pipe   <= {r_rd_pipe[0], mem_rd};
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            cmd_valid   <= 1'b0;
            illegal_cmd <= 1'b0;
            if (w_s) begin
                // Deselect wins over any c edge; a deferred WEL change lands here.
                r_state    <= ST_IDLE;
                r_bit_cnt  <= 5'd0;
                r_out_cnt  <= 3'd0;
                r_shift_in <= 8'h00;
                dq_t       <= 4'b1111;
                dq_o       <= 4'b0000;
                if (r_act == ACT_SET) wel <= 1'b1;
                else if (r_act == ACT_CLR) wel <= 1'b0;
                r_act      <= ACT_NONE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_CMD;
                        r_bit_cnt <= 5'd0;
                    end
                    ST_CMD: if (w_rise) begin
                        r_shift_in <= w_byte;
                        if (r_bit_cnt == 5'd7) begin
                            r_bit_cnt <= 5'd0;
                            cmd_valid <= 1'b1;
                            cmd_byte  <= w_byte;
                            case (w_byte)
                                8'h06: begin r_act <= ACT_SET; r_state <= ST_IGNORE; end
                                8'h04: begin r_act <= ACT_CLR; r_state <= ST_IGNORE; end
                                8'h05: begin
                                    r_state   <= ST_STATUS;
                                    dq_t      <= 4'b1101;
                                    r_out_cnt <= 3'd0;
                                end
                                8'h03: begin r_state <= ST_ADDR; r_after <= ST_READ1; end
`ifdef QUAD_READ_EN
                                8'h6B: begin r_state <= ST_ADDR; r_after <= ST_DUMMY; end
`endif
                                8'h02: begin
                                    r_act   <= ACT_CLR;
                                    r_after <= ST_WRITE;
                                    r_state <= wel ? ST_ADDR : ST_IGNORE;
                                end
                                default: begin
                                    illegal_cmd <= 1'b1;
                                    r_state     <= ST_IGNORE;
                                end
                            endcase
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    ST_ADDR: if (w_rise) begin
                        mem_addr <= {mem_addr[22:0], w_din};
                        if (r_bit_cnt == 5'd23) begin
                            r_bit_cnt <= 5'd0;
                            case (r_after)
                                ST_READ1: begin
                                    r_state   <= ST_READ1;
                                    dq_t      <= 4'b1101;
                                    mem_rd    <= 1'b1;
                                    r_out_cnt <= 3'd0;
                                end
`ifdef QUAD_READ_EN
                                ST_DUMMY: begin
                                    r_state     <= ST_DUMMY;
                                    r_dummy_cnt <= 8'd0;
                                end
`endif
                                ST_WRITE: r_state <= ST_WRITE;
                                default:  r_state <= ST_IGNORE;
                            endcase
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
`ifdef QUAD_READ_EN
                    ST_DUMMY: if (w_rise) begin
                        if (r_dummy_cnt == 8'(QUAD_DUMMY_CLKS - 1)) begin
                            r_state   <= ST_READ4;
                            dq_t      <= 4'b0000;
                            mem_rd    <= 1'b1;
                            r_out_cnt <= 3'd0;
                        end else begin
                            r_dummy_cnt <= r_dummy_cnt + 8'd1;
                        end
                    end
                    ST_READ4: if (w_fall) begin
                        dq_o        <= r_shift_out[7:4];
                        r_shift_out <= {r_shift_out[3:0], 4'b0000};
                        if (r_out_cnt == 3'd1) begin
                            r_out_cnt <= 3'd0;
                            mem_addr  <= mem_addr + 24'd1;
                            mem_rd    <= 1'b1;
                        end else begin
                            r_out_cnt <= r_out_cnt + 3'd1;
                        end
                    end
`endif
                    ST_READ1: if (w_fall) begin
                        dq_o        <= {2'b00, r_shift_out[7], 1'b0};
                        r_shift_out <= {r_shift_out[6:0], 1'b0};
                        if (r_out_cnt == 3'd7) begin
                            // Last bit of the byte is out: prefetch the next address.
                            r_out_cnt <= 3'd0;
                            mem_addr  <= mem_addr + 24'd1;
                            mem_rd    <= 1'b1;
                        end else begin
                            r_out_cnt <= r_out_cnt + 3'd1;
                        end
                    end
                    ST_STATUS: if (w_fall) begin
                        dq_o      <= {2'b00, w_status[3'd7 - r_out_cnt], 1'b0};
                        r_out_cnt <= r_out_cnt + 3'd1;
                    end
                    ST_WRITE: begin
                        // Increment one cycle after the strobe so mem_wr sees the old address.
                        if (mem_wr) mem_addr[7:0] <= mem_addr[7:0] + 8'd1;
                        if (w_rise) begin
                            r_shift_in <= w_byte;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= 5'd0;
                                mem_wr    <= 1'b1;
                                mem_wdata <= w_byte;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: ;
                endcase
                if (w_rdata_valid) r_shift_out <= mem_rdata;
            end
        end
    end
endmodule
